fm_dac_mux: RTL and testbench

FM_DAC_MUX -- requirements
Module: fm_dac_mux

---
 rtl/fm_dac_pkg.sv | 35 +++
 rtl/fm_dac_phase_gen.sv | 42 ++++
 rtl/fm_dac_mux.sv | 148 ++++++++++++++
 tb/tb_fm_dac_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fm_dac_pkg.sv
// Shared types and constants for the FM DAC slot multiplexer.
// FM_DAC_LADDER_EN adds the +1 ladder offset to non-negative slot values.
package fm_dac_pkg;

  localparam int unsigned NUM_SLOTS = 6;
  localparam int unsigned SAMPLE_W  = 10;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  // Raw 10-bit two's-complement sample bits.
  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic [NUM_SLOTS-1:0][SAMPLE_W-1:0] l;
    logic [NUM_SLOTS-1:0][SAMPLE_W-1:0] r;
    logic [NUM_SLOTS-1:0]               mute;
  } frame_t;

  function automatic sample_t slot_value(input sample_t raw, input logic mute);
    sample_t v;
    v = mute ? '0 : raw;
`ifdef FM_DAC_LADDER_EN
    // Non-negative codes move up one step, saturating at the positive limit.
    if (!v[SAMPLE_W-1] && (v != {1'b0, {(SAMPLE_W-1){1'b1}}})) begin
      v = v + sample_t'(1);
    end
`endif
    return v;
  endfunction

endpackage

// File: rtl/fm_dac_phase_gen.sv
// Half-period counter and registered fm_clk1 for the FM DAC slot multiplexer.
module fm_dac_phase_gen #(
  parameter int unsigned HALF_DIV = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic high_next,
  output logic fm_clk1,
  output logic phase_end
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fm_clk1_q;

  assign phase_end = run && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || phase_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      fm_clk1_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fm_clk1_q <= high_next;
    end
  end

  assign fm_clk1 = fm_clk1_q;

endmodule

// File: rtl/fm_dac_mux.sv
// Six-slot time-multiplexer feeding an FM DAC; one frame per sample_ce.
// Define FM_DAC_LADDER_EN to offset non-negative outputs by +1.
module fm_dac_mux
  import fm_dac_pkg::*;
#(
  parameter int unsigned HALF_DIV = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_ce,
  input  logic [NUM_SLOTS*SAMPLE_W-1:0] ch_l,
  input  logic [NUM_SLOTS*SAMPLE_W-1:0] ch_r,
  input  logic [NUM_SLOTS-1:0]          ch_mute,
  output logic                          fm_clk1,
  output logic                          fm_sel23,
  output logic [SAMPLE_W-1:0]           mo_l,
  output logic [SAMPLE_W-1:0]           mo_r,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam logic [2:0] LastSlot = 3'(NUM_SLOTS - 1);

  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  frame_t     active_q, active_d;
  frame_t     pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_done_q, frame_done_d;
  logic       sel23_q, sel23_d;
  sample_t    mo_l_q, mo_l_d;
  sample_t    mo_r_q, mo_r_d;
  frame_t     in_frame;
  logic       start;
  logic       phase_end;

  assign in_frame.l    = ch_l;
  assign in_frame.r    = ch_r;
  assign in_frame.mute = ch_mute;

  fm_dac_phase_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_phase_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (state_q != StIdle),
    .high_next (state_d == StHigh),
    .fm_clk1   (fm_clk1),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    mo_l_d       = mo_l_q;
    mo_r_d       = mo_r_q;
    start        = 1'b0;

    unique case (state_q)
      StIdle: start = sample_ce | pend_valid_q;
      StHigh: if (phase_end) state_d = StLow;
      StLow: begin
        if (phase_end) begin
          if (slot_q == LastSlot) begin
            frame_done_d = 1'b1;
            if (sample_ce || pend_valid_q) begin
              start = 1'b1;
            end else begin
              state_d = StIdle;
              slot_d  = '0;
              mo_l_d  = '0;
              mo_r_d  = '0;
            end
          end else begin
            state_d = StHigh;
            slot_d  = slot_q + 3'd1;
            mo_l_d  = slot_value(active_q.l[slot_d], active_q.mute[slot_d]);
            mo_r_d  = slot_value(active_q.r[slot_d], active_q.mute[slot_d]);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pending frame always goes first; a simultaneous strobe refills pending.
    if (start) begin
      state_d = StHigh;
      slot_d  = '0;
      if (pend_valid_q) begin
        active_d = pend_q;
        if (sample_ce) begin
          pend_d = in_frame;
        end else begin
          pend_valid_d = 1'b0;
        end
      end else begin
        active_d = in_frame;
      end
      mo_l_d = slot_value(active_d.l[0], active_d.mute[0]);
      mo_r_d = slot_value(active_d.r[0], active_d.mute[0]);
    end else if (sample_ce) begin
      if (pend_valid_q) overrun_d = 1'b1;
      pend_d       = in_frame;
      pend_valid_d = 1'b1;
    end

    sel23_d = (state_d != StIdle) && (slot_d == LastSlot);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sel23_q      <= 1'b0;
      mo_l_q       <= '0;
      mo_r_q       <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      sel23_q      <= sel23_d;
      mo_l_q       <= mo_l_d;
      mo_r_q       <= mo_r_d;
    end
  end

  assign fm_sel23   = sel23_q;
  assign mo_l       = mo_l_q;
  assign mo_r       = mo_r_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fm_dac_mux.sv
// Directed self-checking bench for fm_dac_mux with HALF_DIV = 6.
module tb_fm_dac_mux;

  logic        clk;
  logic        reset_n;
  logic        sample_ce;
  logic [59:0] ch_l;
  logic [59:0] ch_r;
  logic [5:0]  ch_mute;
  logic        fm_clk1;
  logic        fm_sel23;
  logic [9:0]  mo_l;
  logic [9:0]  mo_r;
  logic        frame_done;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Expected frame currently on the wire.
  logic [59:0] exp_l, exp_r;
  logic [5:0]  exp_m;

  // Up to two strobes injected while a frame is checked.
  int          inj_cyc [2];
  logic [59:0] inj_l   [2];
  logic [59:0] inj_r   [2];
  logic [5:0]  inj_m   [2];

  fm_dac_mux #(
    .HALF_DIV (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_ce  (sample_ce),
    .ch_l       (ch_l),
    .ch_r       (ch_r),
    .ch_mute    (ch_mute),
    .fm_clk1    (fm_clk1),
    .fm_sel23   (fm_sel23),
    .mo_l       (mo_l),
    .mo_r       (mo_r),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] mk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [9:0] exp_out(input logic [9:0] raw, input logic m);
    logic [9:0] v;
    v = m ? 10'd0 : raw;
`ifdef FM_DAC_LADDER_EN
    if (!v[9] && v != 10'h1ff) v = v + 10'd1;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inj();
    inj_cyc[0] = -1;
    inj_cyc[1] = -1;
  endtask

  task automatic start_frame(input logic [59:0] l, input logic [59:0] r, input logic [5:0] m);
    tick();
    ch_l = l; ch_r = r; ch_mute = m; sample_ce = 1'b1;
    exp_l = l; exp_r = r; exp_m = m;
    tick();
  endtask

  // Walks all 72 clks of one frame; the caller has already placed us in clk 0.
  task automatic check_frame(input bit chained);
    int         slot;
    logic [9:0] el, er;
    for (int cyc = 0; cyc < 72; cyc++) begin
      if (cyc > 0) tick();
      slot = cyc / 12;
      el = exp_out(exp_l[slot*10 +: 10], exp_m[slot]);
      er = exp_out(exp_r[slot*10 +: 10], exp_m[slot]);
      chk("fm_clk1", 32'(fm_clk1), 32'((cyc % 12) < 6));
      chk("fm_sel23", 32'(fm_sel23), 32'(slot == 5));
      chk("mo_l", 32'(mo_l), 32'(el));
      chk("mo_r", 32'(mo_r), 32'(er));
      chk("frame_done", 32'(frame_done), 32'(chained && cyc == 0));
      sample_ce = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (inj_cyc[k] == cyc) begin
          ch_l = inj_l[k]; ch_r = inj_r[k]; ch_mute = inj_m[k]; sample_ce = 1'b1;
        end
      end
    end
  endtask

  task automatic end_idle();
    tick();
    sample_ce = 1'b0;
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("idle_clk1", 32'(fm_clk1), 32'd0);
    chk("idle_sel23", 32'(fm_sel23), 32'd0);
    chk("idle_mo_l", 32'(mo_l), 32'd0);
    chk("idle_mo_r", 32'(mo_r), 32'd0);
    tick();
    chk("done_single", 32'(frame_done), 32'd0);
    chk("idle_clk1_2", 32'(fm_clk1), 32'd0);
  endtask

  initial begin
    logic [59:0] fa_l, fa_r, fb_l, fb_r, fc_l, fc_r;
    fa_l = mk(0, 10, 20, 30, 40, 50);
    fa_r = mk(0, -1, -2, -3, -4, -5);
    fb_l = mk(100, 101, 102, 103, 104, 105);
    fb_r = mk(-20, -21, -22, -23, -24, -25);
    fc_l = mk(-100, 7, 200, -300, 400, 511);
    fc_r = mk(9, -9, 19, -19, 29, -512);

    reset_n = 1'b0; sample_ce = 1'b0; ch_l = '0; ch_r = '0; ch_mute = '0;
    clear_inj();
    tick(); tick();
    chk("rst_clk1", 32'(fm_clk1), 32'd0);
    chk("rst_sel23", 32'(fm_sel23), 32'd0);
    chk("rst_mo_l", 32'(mo_l), 32'd0);
    chk("rst_mo_r", 32'(mo_r), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_clk1_pre", 32'(fm_clk1), 32'd0);

    // Basic frame, fm_clk1 high one clk after the strobe.
    start_frame(fa_l, fa_r, 6'b000000);
    check_frame(1'b0);
    end_idle();

    // Channel 2 muted.
    start_frame(fa_l, fa_r, 6'b000100);
    check_frame(1'b0);
    end_idle();

    // Second strobe mid-frame runs back to back.
    start_frame(fa_l, fa_r, 6'b000000);
    inj_cyc[0] = 30; inj_l[0] = fb_l; inj_r[0] = fb_r; inj_m[0] = 6'b000000;
    check_frame(1'b0);
    clear_inj();
    exp_l = fb_l; exp_r = fb_r; exp_m = 6'b000000;
    tick();
    check_frame(1'b1);
    chk("no_overrun", 32'(overrun), 32'd0);
    end_idle();

    // Strobe coinciding with frame completion.
    start_frame(fa_l, fa_r, 6'b000000);
    inj_cyc[0] = 71; inj_l[0] = fc_l; inj_r[0] = fc_r; inj_m[0] = 6'b100001;
    check_frame(1'b0);
    clear_inj();
    exp_l = fc_l; exp_r = fc_r; exp_m = 6'b100001;
    tick();
    check_frame(1'b1);
    chk("no_overrun_2", 32'(overrun), 32'd0);
    end_idle();

    // Three strobes in one frame: the middle one is dropped.
    start_frame(fa_l, fa_r, 6'b000000);
    inj_cyc[0] = 20; inj_l[0] = fb_l; inj_r[0] = fb_r; inj_m[0] = 6'b000000;
    inj_cyc[1] = 40; inj_l[1] = fc_l; inj_r[1] = fc_r; inj_m[1] = 6'b000000;
    check_frame(1'b0);
    clear_inj();
    chk("overrun_set", 32'(overrun), 32'd1);
    exp_l = fc_l; exp_r = fc_r; exp_m = 6'b000000;
    tick();
    check_frame(1'b1);
    end_idle();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in slot 3 aborts the frame.
    start_frame(fb_l, fb_r, 6'b000000);
    sample_ce = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("pre_rst_clk1", 32'(fm_clk1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_clk1", 32'(fm_clk1), 32'd0);
    chk("arst_mo_l", 32'(mo_l), 32'd0);
    chk("arst_mo_r", 32'(mo_r), 32'd0);
    chk("arst_sel23", 32'(fm_sel23), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_done", 32'(frame_done), 32'd0);
      chk("abort_idle", 32'(fm_clk1), 32'd0);
    end
    start_frame(fa_l, fa_r, 6'b000000);
    check_frame(1'b0);
    end_idle();

    // Ladder boundary samples, plus a muted channel.
    start_frame(mk(0, 511, -5, 1, -512, 510), mk(-1, 0, 511, 3, -5, 0), 6'b100000);
    check_frame(1'b0);
    end_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
